// File: rtl/cache_control.sv
// Controller FSM for a set-associative cache: sequences hit service, dirty-victim
// writeback and line fill. Performance counters are built only with CACHE_PERF_CNT_EN.
module cache_control #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_read,
  input  logic mem_write,
  output logic mem_resp,
  input  logic cache_hit,
  input  logic lru_dirty_miss,
  input  logic pmem_resp,
  output logic pmem_read,
  output logic pmem_write,
  output logic cache_read,
  output logic cache_write,
  output logic cache_load,
  output logic dirty_load,
  output logic dirty_in,
  output logic lru_load
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    FILL
  } state_e;

  state_e state_q, state_d;
  logic   req;

  if (CNT_WIDTH == 0) begin : g_bad_cnt_width
    $error("cache_control: CNT_WIDTH must be nonzero");
  end

  assign req = mem_read | mem_write;

  always_comb begin
    state_d     = state_q;
    mem_resp    = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    cache_read  = 1'b0;
    cache_write = 1'b0;
    cache_load  = 1'b0;
    dirty_load  = 1'b0;
    dirty_in    = 1'b0;
    lru_load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) state_d = COMPARE;
      end
      COMPARE: begin
        if (!req) begin
          state_d = IDLE;
        end else if (cache_hit) begin
          mem_resp = 1'b1;
          lru_load = 1'b1;
          // Write wins when both request lines are (illegally) high.
          if (mem_write) begin
            cache_write = 1'b1;
            dirty_load  = 1'b1;
            dirty_in    = 1'b1;
          end else begin
            cache_read = 1'b1;
          end
          state_d = IDLE;
        end else begin
          state_d = lru_dirty_miss ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          dirty_load = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          cache_load = 1'b1;
          dirty_load = 1'b1;
          state_d    = COMPARE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic                 refill_q;
  logic [CNT_WIDTH-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
  logic                 hit_evt, miss_evt, wb_evt;

  // The re-compare after a fill is not a CPU-visible hit, hence the refill flag.
  assign hit_evt  = (state_q == COMPARE) && req && cache_hit && !refill_q;
  assign miss_evt = (state_q == COMPARE) && req && !cache_hit;
  assign wb_evt   = (state_q == WRITEBACK) && pmem_resp;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      refill_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if ((state_q == IDLE) && req) begin
        refill_q <= 1'b0;
      end else if ((state_q == FILL) && pmem_resp) begin
        refill_q <= 1'b1;
      end
      if (hit_evt)  hit_cnt_q  <= sat_inc(hit_cnt_q);
      if (miss_evt) miss_cnt_q <= sat_inc(miss_cnt_q);
      if (wb_evt)   wb_cnt_q   <= sat_inc(wb_cnt_q);
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: per-cycle expected strobe vectors are derived
// from transaction-level rules (hit / clean miss / dirty miss) and compared each cycle.
module tb_cache_control;

  logic clk = 1'b0;
  logic rst, mem_read, mem_write, cache_hit, lru_dirty_miss, pmem_resp;
  logic mem_resp, pmem_read, pmem_write, cache_read, cache_write;
  logic cache_load, dirty_load, dirty_in, lru_load;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  cache_control #(.CNT_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_resp       (mem_resp),
    .cache_hit      (cache_hit),
    .lru_dirty_miss (lru_dirty_miss),
    .pmem_resp      (pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .cache_read     (cache_read),
    .cache_write    (cache_write),
    .cache_load     (cache_load),
    .dirty_load     (dirty_load),
    .dirty_in       (dirty_in),
    .lru_load       (lru_load)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count),
    .wb_count       (wb_count)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [8:0] M_RESP = 9'h100;
  localparam logic [8:0] M_PRD  = 9'h080;
  localparam logic [8:0] M_PWR  = 9'h040;
  localparam logic [8:0] M_CRD  = 9'h020;
  localparam logic [8:0] M_CWR  = 9'h010;
  localparam logic [8:0] M_CLD  = 9'h008;
  localparam logic [8:0] M_DLD  = 9'h004;
  localparam logic [8:0] M_DIN  = 9'h002;
  localparam logic [8:0] M_LRU  = 9'h001;

  typedef struct {
    logic [8:0] v;
    string      name;
    bit         mark;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_n    = 0;
  int   start_cyc = 0;
  int   resp_cyc  = -1;
  int   prd_cycles = 0;
  int   pwr_cycles = 0;
  int   m_hits = 0, m_miss = 0, m_wb = 0;

  logic [8:0] act;
  assign act = {mem_resp, pmem_read, pmem_write, cache_read, cache_write,
                cache_load, dirty_load, dirty_in, lru_load};

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  // Compare process: one expected vector per driven cycle, checked mid-cycle.
  always @(negedge clk) begin : compare
    exp_t e;
    cyc_n++;
    if (mem_resp === 1'b1) resp_cyc = cyc_n;
    if (pmem_read === 1'b1) prd_cycles++;
    if (pmem_write === 1'b1) pwr_cycles++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.mark) start_cyc = cyc_n;
      chk(e.name, 64'(act), 64'(e.v));
    end
  end

  task automatic cyc(input bit rd, input bit wr, input bit hit, input bit dm, input bit pr,
                     input logic [8:0] e, input string nm,
                     input bit rstn = 1'b1, input bit mark = 1'b0);
    exp_t x;
    @(posedge clk);
    #1;
    mem_read       = rd;
    mem_write      = wr;
    cache_hit      = hit;
    lru_dirty_miss = dm;
    pmem_resp      = pr;
    rst            = rstn;
    x.v    = e;
    x.name = nm;
    x.mark = mark;
    exp_q.push_back(x);
  endtask

  function automatic logic [8:0] hit_vec(input bit wr);
    return wr ? (M_RESP | M_LRU | M_CWR | M_DLD | M_DIN) : (M_RESP | M_LRU | M_CRD);
  endfunction

  // Whole CPU transaction; stray pmem_resp in IDLE and in a missing COMPARE must be ignored.
  task automatic request(input bit rd, input bit wr, input bit hit, input bit vdirty,
                         input int wb_lat, input int fill_lat, input string nm);
    cyc(rd, wr, 1'b0, 1'b0, 1'b1, '0, {nm, "/idle"}, 1'b1, 1'b1);
    if (hit) begin
      cyc(rd, wr, 1'b1, 1'b0, 1'b0, hit_vec(wr), {nm, "/hit"});
      m_hits++;
    end else begin
      cyc(rd, wr, 1'b0, vdirty, 1'b1, '0, {nm, "/cmp_miss"});
      m_miss++;
      if (vdirty) begin
        for (int i = 1; i <= wb_lat; i++)
          cyc(rd, wr, 1'b0, 1'b0, i == wb_lat, (i == wb_lat) ? (M_PWR | M_DLD) : M_PWR,
              {nm, "/wb"});
        m_wb++;
      end
      for (int i = 1; i <= fill_lat; i++)
        cyc(rd, wr, 1'b0, 1'b0, i == fill_lat,
            (i == fill_lat) ? (M_PRD | M_CLD | M_DLD) : M_PRD, {nm, "/fill"});
      cyc(rd, wr, 1'b1, 1'b0, 1'b0, hit_vec(wr), {nm, "/recmp"});
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, {nm, "/idle_after"});
  endtask

  task automatic check_perf(input string nm);
`ifdef CACHE_PERF_CNT_EN
    chk({nm, "/hit_count"},  64'(hit_count),  64'(m_hits));
    chk({nm, "/miss_count"}, 64'(miss_count), 64'(m_miss));
    chk({nm, "/wb_count"},   64'(wb_count),   64'(m_wb));
`else
    if (nm.len() == 0) $display("check_perf called without a name");
`endif
  endtask

  initial begin : stim
    int p0, w0, r0;
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    cache_hit = 1'b0; lru_dirty_miss = 1'b0; pmem_resp = 1'b0;

    cyc(0, 0, 0, 0, 0, '0, "reset0", 1'b0);
    cyc(0, 0, 0, 0, 1, '0, "reset1", 1'b0);
    cyc(0, 0, 0, 0, 0, '0, "idle0");
    check_perf("reset");

    p0 = prd_cycles; w0 = pwr_cycles;
    request(1, 0, 1, 0, 0, 0, "rd_hit");
    chk("rd_hit_latency", 64'(resp_cyc - start_cyc), 64'd1);
    chk("rd_hit_no_pmem", 64'((prd_cycles - p0) + (pwr_cycles - w0)), 64'd0);

    request(0, 1, 1, 0, 0, 0, "wr_hit");
    chk("wr_hit_latency", 64'(resp_cyc - start_cyc), 64'd1);
    request(1, 0, 1, 0, 0, 0, "rd_after_wr");

    p0 = prd_cycles;
    request(1, 0, 0, 0, 0, 5, "rd_miss");
    chk("rd_miss_latency", 64'(resp_cyc - start_cyc), 64'd7);
    chk("rd_miss_pmem_read_cycles", 64'(prd_cycles - p0), 64'd5);
    check_perf("rd_miss");

    p0 = prd_cycles; w0 = pwr_cycles;
    request(0, 1, 0, 1, 3, 4, "wr_dmiss");
    chk("wr_dmiss_latency", 64'(resp_cyc - start_cyc), 64'd9);
    chk("wr_dmiss_pmem_write_cycles", 64'(pwr_cycles - w0), 64'd3);
    chk("wr_dmiss_pmem_read_cycles", 64'(prd_cycles - p0), 64'd4);
`ifdef CACHE_PERF_CNT_EN
    chk("wr_dmiss_wb_literal", 64'(wb_count), 64'd1);
`endif
    check_perf("wr_dmiss");

    request(1, 1, 1, 0, 0, 0, "rdwr_hit");
    chk("rdwr_hit_latency", 64'(resp_cyc - start_cyc), 64'd1);

    // Request withdrawn mid-fill: fill completes, no response.
    r0 = resp_cyc;
    cyc(1, 0, 0, 0, 0, '0, "drop/idle", 1'b1, 1'b1);
    cyc(1, 0, 0, 0, 0, '0, "drop/cmp");
    cyc(0, 0, 0, 0, 0, M_PRD, "drop/fill1");
    cyc(0, 0, 0, 0, 1, M_PRD | M_CLD | M_DLD, "drop/fill2");
    cyc(0, 0, 1, 0, 0, '0, "drop/cmp_noresp");
    cyc(0, 0, 0, 0, 0, '0, "drop/idle_after");
    m_miss++;
    chk("drop_no_resp", 64'(resp_cyc), 64'(r0));

    // Re-compare misses after a fill: second fill, then hit; no extra hit counted.
    cyc(1, 0, 0, 0, 0, '0, "pfm/idle", 1'b1, 1'b1);
    cyc(1, 0, 0, 0, 0, '0, "pfm/cmp");
    cyc(1, 0, 0, 0, 0, M_PRD, "pfm/fill_a1");
    cyc(1, 0, 0, 0, 1, M_PRD | M_CLD | M_DLD, "pfm/fill_a2");
    cyc(1, 0, 0, 0, 0, '0, "pfm/recmp_miss");
    cyc(1, 0, 0, 0, 0, M_PRD, "pfm/fill_b1");
    cyc(1, 0, 0, 0, 1, M_PRD | M_CLD | M_DLD, "pfm/fill_b2");
    cyc(1, 0, 1, 0, 0, hit_vec(1'b0), "pfm/recmp_hit");
    cyc(0, 0, 0, 0, 0, '0, "pfm/idle_after");
    m_miss += 2;
    chk("pfm_latency", 64'(resp_cyc - start_cyc), 64'd7);
    check_perf("pfm");

    // Reset asserted in the second FILL cycle.
    cyc(1, 0, 0, 0, 0, '0, "rstf/idle", 1'b1, 1'b1);
    cyc(1, 0, 0, 0, 0, '0, "rstf/cmp");
    cyc(1, 0, 0, 0, 0, M_PRD, "rstf/fill1");
    cyc(1, 0, 0, 0, 0, M_PRD, "rstf/fill2", 1'b0);
    m_hits = 0; m_miss = 0; m_wb = 0;
    cyc(0, 0, 0, 0, 1, '0, "rstf/after");
    cyc(0, 0, 0, 0, 0, '0, "rstf/idle2");
    check_perf("rstf");

    request(1, 0, 0, 0, 0, 2, "fresh");
    chk("fresh_latency", 64'(resp_cyc - start_cyc), 64'd4);
    check_perf("fresh");

    cyc(0, 0, 0, 0, 0, '0, "final_idle");
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
